// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) arbiter and response router for a two-bank interleaved data memory.
// Define DMEM_ARB_STATS_EN to build the saturating core stall counter on stall_cnt_o.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BANK_AW  = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [ADDR_W-1:0]     core_addr_i,
    input  logic [DATA_W-1:0]     core_wdata_i,
    input  logic [DATA_W/8-1:0]   core_be_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [DATA_W-1:0]     core_rdata_o,

    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [ADDR_W-1:0]     dbg_addr_i,
    input  logic [DATA_W-1:0]     dbg_wdata_i,
    input  logic [DATA_W/8-1:0]   dbg_be_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [DATA_W-1:0]     dbg_rdata_o,

    input  logic                  dbg_lock_i,
    output logic                  lock_o,

    output logic [1:0]            bank_cs_o,
    output logic                  bank_we_o,
    output logic [BANK_AW-1:0]    bank_addr_o,
    output logic [DATA_W-1:0]     bank_wdata_o,
    output logic [DATA_W/8-1:0]   bank_be_o,
    input  logic [DATA_W-1:0]     bank0_rdata_i,
    input  logic [DATA_W-1:0]     bank1_rdata_i,

    output logic [15:0]           stall_cnt_o
);

    localparam int BE_W   = DATA_W / 8;
    localparam int NP     = 2;
    localparam int P_CORE = 0;
    localparam int P_DBG  = 1;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic {
        ST_SHARED = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // In-flight access: owner (0 = core, 1 = debug), bank, plus valid and write flags
    logic fl_valid_q, fl_valid_d;
    logic fl_owner_q, fl_owner_d;
    logic fl_bank_q,  fl_bank_d;
    logic fl_we_q,    fl_we_d;

    // Both requester ports gathered into arrays indexed by port number
    logic [NP-1:0]      p_req;
    logic [NP-1:0]      p_we;
    logic [NP-1:0]      p_bank;
    logic [NP-1:0]      p_gnt;
    logic [NP-1:0]      p_rvalid;
    logic [ADDR_W-1:0]  p_addr  [NP];
    logic [BANK_AW-1:0] p_waddr [NP];
    logic [DATA_W-1:0]  p_wdata [NP];
    logic [BE_W-1:0]    p_be    [NP];
    logic [DATA_W-1:0]  p_rdata [NP];

    logic              win_any;
    logic              win_sel;
    logic [DATA_W-1:0] rsp_data;

    assign p_req      = {dbg_req_i, core_req_i};
    assign p_we       = {dbg_we_i,  core_we_i};
    assign p_addr[0]  = core_addr_i;
    assign p_addr[1]  = dbg_addr_i;
    assign p_wdata[0] = core_wdata_i;
    assign p_wdata[1] = dbg_wdata_i;
    assign p_be[0]    = core_be_i;
    assign p_be[1]    = dbg_be_i;

    // Byte address: bit 2 picks the bank, the bits above it form the bank word address
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_decode
            logic unused_addr_bits;
            assign p_bank[gi]       = p_addr[gi][2];
            assign p_waddr[gi]      = p_addr[gi][BANK_AW+2:3];
            assign unused_addr_bits = ^{p_addr[gi][1:0], p_addr[gi][ADDR_W-1:BANK_AW+3]};
        end
    endgenerate

    // Arbitration and lock sequencing; nothing is granted while reset is asserted
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        p_gnt      = '0;
        if (rst_i) begin
            unique case (state_q)
                ST_SHARED: begin
                    if (p_req[P_CORE] && !(p_req[P_DBG] && (wait_cnt_q == MAX_WAIT_C))) begin
                        p_gnt[P_CORE] = 1'b1;
                    end else begin
                        p_gnt[P_DBG] = p_req[P_DBG];
                    end
                    if (!p_req[P_DBG] || p_gnt[P_DBG]) begin
                        wait_cnt_d = 4'd0;
                    end else if (wait_cnt_q != 4'hF) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
                ST_LOCKED: begin
                    p_gnt[P_DBG] = p_req[P_DBG];
                    wait_cnt_d   = 4'd0;
                end
                default: begin
                    wait_cnt_d = 4'd0;
                end
            endcase
            state_d = dbg_lock_i ? ST_LOCKED : ST_SHARED;
        end
    end

    assign core_gnt_o = p_gnt[P_CORE];
    assign dbg_gnt_o  = p_gnt[P_DBG];
    assign lock_o     = (state_q == ST_LOCKED);

    assign win_any = |p_gnt;
    assign win_sel = p_gnt[P_DBG];

    // Winner drives the shared bank bus; everything idles at zero without a grant
    always_comb begin
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        if (win_any) begin
            bank_we_o    = p_we[win_sel];
            bank_addr_o  = p_waddr[win_sel];
            bank_wdata_o = p_wdata[win_sel];
            bank_be_o    = p_be[win_sel];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_cs
            assign bank_cs_o[gi] = win_any && (p_bank[win_sel] == 1'(gi));
        end
    endgenerate

    always_comb begin
        fl_valid_d = win_any;
        fl_owner_d = win_sel;
        fl_bank_d  = p_bank[win_sel];
        fl_we_d    = p_we[win_sel];
    end

    // Writes still produce a response pulse, but with zero data
    always_comb begin
        rsp_data = '0;
        if (!fl_we_q) begin
            rsp_data = fl_bank_q ? bank1_rdata_i : bank0_rdata_i;
        end
    end

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_rsp
            assign p_rvalid[gi] = fl_valid_q && (fl_owner_q == 1'(gi));
            assign p_rdata[gi]  = p_rvalid[gi] ? rsp_data : '0;
        end
    endgenerate

    assign core_rvalid_o = p_rvalid[P_CORE];
    assign dbg_rvalid_o  = p_rvalid[P_DBG];
    assign core_rdata_o  = p_rdata[P_CORE];
    assign dbg_rdata_o   = p_rdata[P_DBG];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_SHARED;
            wait_cnt_q <= 4'd0;
            fl_valid_q <= 1'b0;
            fl_owner_q <= 1'b0;
            fl_bank_q  <= 1'b0;
            fl_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fl_valid_q <= fl_valid_d;
            fl_owner_q <= fl_owner_d;
            fl_bank_q  <= fl_bank_d;
            fl_we_q    <= fl_we_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (core_req_i && !core_gnt_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'd0;
`endif

endmodule
